// File: rtl/vram_dma_if.sv
// vram_dma_if: CPU register port, memory bus and VRAM write signals of the DMA
interface vram_dma_if #(parameter int VRAM_ADDR_W = 12);
  logic                   reg_write;
  logic [2:0]             reg_addr;
  logic [7:0]             reg_wdata;
  logic [7:0]             reg_rdata;
  logic                   bus_request;
  logic                   bus_grant;
  logic [15:0]            mem_addr;
  logic                   mem_rd;
  logic [7:0]             mem_rdata;
  logic [7:0]             vram_data;
  logic [VRAM_ADDR_W-1:0] vram_address;
  logic                   vram_write_enable;
  logic                   SELECT_pmf, SELECT_pmb, SELECT_ntbl, SELECT_obm, SELECT_txbl;
  modport master (
    input  reg_write, reg_addr, reg_wdata, bus_grant, mem_rdata,
    output reg_rdata, bus_request, mem_addr, mem_rd, vram_data, vram_address, vram_write_enable,
           SELECT_pmf, SELECT_pmb, SELECT_ntbl, SELECT_obm, SELECT_txbl
  );
  modport slave (
    output reg_write, reg_addr, reg_wdata, bus_grant, mem_rdata,
    input  reg_rdata, bus_request, mem_addr, mem_rd, vram_data, vram_address, vram_write_enable,
           SELECT_pmf, SELECT_pmb, SELECT_ntbl, SELECT_obm, SELECT_txbl
  );
endinterface

// File: rtl/vram_dma.sv
// vram_dma: copies a block from CPU memory into a selected VRAM region during vblank
module vram_dma #(parameter int VRAM_ADDR_W = 12) (
  input  logic       cpu_clk,
  input  logic       rst,
  vram_dma_if.master bus,
  input  logic       in_vblank,
  output logic       done_irq
);
  localparam logic [2:0] IDLE = 3'd0, WAIT_VB = 3'd1, REQ = 3'd2, READ = 3'd3, WRITE = 3'd4;
  logic [2:0]             state_q, state_d;
  logic [7:0]             src_hi_q, src_hi_d, src_lo_q, src_lo_d, len_q, len_d;
  logic [7:0]             dest_lo_q, dest_lo_d, dest_hi_q, dest_hi_d;
  logic [2:0]             sel_q, sel_d, w_sel_q, w_sel_d;
  logic [15:0]            w_src_q, w_src_d;
  logic [VRAM_ADDR_W-1:0] w_dest_q, w_dest_d;
  logic [8:0]             w_cnt_q, w_cnt_d;
  logic                   done_q, done_d;
  logic                   busy, cfg_wr, ctrl_wr, start, last, rd, wr;
  assign busy    = state_q != IDLE;
  assign cfg_wr  = bus.reg_write && !busy;
  assign ctrl_wr = bus.reg_write && bus.reg_addr == 3'd6;
  assign start   = ctrl_wr && bus.reg_wdata[0] && !busy && sel_q <= 3'd4;
  assign rd      = state_q == READ;
  assign wr      = state_q == WRITE;
  assign last    = wr && w_cnt_q == 9'd1;
  // register file, working copies, transfer sequencing and irq
  always_comb begin
    src_hi_d  = cfg_wr && bus.reg_addr == 3'd0 ? bus.reg_wdata : src_hi_q;
    src_lo_d  = cfg_wr && bus.reg_addr == 3'd1 ? bus.reg_wdata : src_lo_q;
    len_d     = cfg_wr && bus.reg_addr == 3'd2 ? bus.reg_wdata : len_q;
    sel_d     = cfg_wr && bus.reg_addr == 3'd3 ? bus.reg_wdata[2:0] : sel_q;
    dest_lo_d = cfg_wr && bus.reg_addr == 3'd4 ? bus.reg_wdata : dest_lo_q;
    dest_hi_d = cfg_wr && bus.reg_addr == 3'd5 ? bus.reg_wdata : dest_hi_q;
    w_src_d   = start ? {src_hi_q, src_lo_q} : wr ? w_src_q + 16'd1 : w_src_q;
    w_dest_d  = start ? VRAM_ADDR_W'({dest_hi_q, dest_lo_q}) : wr ? w_dest_q + 1'b1 : w_dest_q;
    w_cnt_d   = start ? (len_q == 8'd0 ? 9'd256 : {1'b0, len_q}) : wr ? w_cnt_q - 9'd1 : w_cnt_q;
    w_sel_d   = start ? sel_q : w_sel_q;
    done_d    = last ? 1'b1 : ctrl_wr && bus.reg_wdata[1] ? 1'b0 : done_q;
    state_d   = start ? WAIT_VB :
                state_q == WAIT_VB ? (in_vblank ? REQ : WAIT_VB) :
                state_q == REQ ? (bus.bus_grant ? READ : REQ) :
                rd ? WRITE :
                wr ? (last ? IDLE : in_vblank && bus.bus_grant ? READ : !in_vblank ? WAIT_VB : REQ) :
                IDLE;
  end
  // state and register update with synchronous reset
  always_ff @(posedge cpu_clk) begin
    if (rst) begin
      state_q   <= IDLE;
      src_hi_q  <= '0;
      src_lo_q  <= '0;
      len_q     <= '0;
      sel_q     <= '0;
      dest_lo_q <= '0;
      dest_hi_q <= '0;
      w_src_q   <= '0;
      w_dest_q  <= '0;
      w_cnt_q   <= '0;
      w_sel_q   <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      src_hi_q  <= src_hi_d;
      src_lo_q  <= src_lo_d;
      len_q     <= len_d;
      sel_q     <= sel_d;
      dest_lo_q <= dest_lo_d;
      dest_hi_q <= dest_hi_d;
      w_src_q   <= w_src_d;
      w_dest_q  <= w_dest_d;
      w_cnt_q   <= w_cnt_d;
      w_sel_q   <= w_sel_d;
      done_q    <= done_d;
    end
  end
  // bus, VRAM and register read outputs, zero outside the active phases
  always_comb begin
    bus.bus_request       = state_q == REQ || rd || wr;
    bus.mem_rd            = rd;
    bus.mem_addr          = rd ? w_src_q : '0;
    bus.vram_write_enable = wr;
    bus.vram_data         = wr ? bus.mem_rdata : '0;
    bus.vram_address      = wr ? w_dest_q : '0;
    bus.SELECT_pmf        = wr && w_sel_q == 3'd0;
    bus.SELECT_pmb        = wr && w_sel_q == 3'd1;
    bus.SELECT_ntbl       = wr && w_sel_q == 3'd2;
    bus.SELECT_obm        = wr && w_sel_q == 3'd3;
    bus.SELECT_txbl       = wr && w_sel_q == 3'd4;
    bus.reg_rdata         = bus.reg_addr == 3'd0 ? src_hi_q :
                            bus.reg_addr == 3'd1 ? src_lo_q :
                            bus.reg_addr == 3'd2 ? len_q :
                            bus.reg_addr == 3'd3 ? {5'b0, sel_q} :
                            bus.reg_addr == 3'd4 ? dest_lo_q :
                            bus.reg_addr == 3'd5 ? dest_hi_q :
                            bus.reg_addr == 3'd6 ? {5'b0, state_q == WAIT_VB, done_q, busy} : 8'h00;
  end
  assign done_irq = done_q;
endmodule

// File: tb/tb_vram_dma.sv
// tb_vram_dma: scoreboard bench for vram_dma reads, VRAM writes, irq and reset
module tb_vram_dma;
  logic clk = 0, rst = 1, vb = 0, done_irq;
  int n_tests = 0, n_fail = 0;
  typedef struct {logic [15:0] src; logic [11:0] dest; logic [2:0] sel;} exp_t;
  logic [15:0] exp_rd[$];
  exp_t exp_wr[$];
  exp_t e;
  logic [4:0] sel_v;
  vram_dma_if #(.VRAM_ADDR_W(12)) bus();
  vram_dma #(.VRAM_ADDR_W(12)) dut(.cpu_clk(clk), .rst(rst), .bus(bus), .in_vblank(vb), .done_irq(done_irq));
  always #5 clk = ~clk;
  function automatic logic [7:0] mem_f(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction
  always @(posedge clk) bus.mem_rdata <= bus.mem_rd ? mem_f(bus.mem_addr) : 8'hEE;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  always @(negedge clk) begin
    sel_v = {bus.SELECT_txbl, bus.SELECT_obm, bus.SELECT_ntbl, bus.SELECT_pmb, bus.SELECT_pmf};
    if (bus.mem_rd) begin
      if (exp_rd.size() == 0) chk("rd_unexpected", exp_rd.size(), 1);
      else chk("rd_addr", bus.mem_addr, exp_rd.pop_front());
    end else chk("rd_idle", bus.mem_addr, 0);
    if (bus.vram_write_enable) begin
      if (exp_wr.size() == 0) chk("wr_unexpected", exp_wr.size(), 1);
      else begin
        e = exp_wr.pop_front();
        chk("wr_addr", bus.vram_address, e.dest);
        chk("wr_data", bus.vram_data, mem_f(e.src));
        chk("wr_sel", sel_v, 5'b1 << e.sel);
      end
    end else chk("wr_idle", {sel_v, bus.vram_address, bus.vram_data}, 0);
  end
  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    bus.reg_addr = a; bus.reg_wdata = d; bus.reg_write = 1;
    @(posedge clk); #1;
    bus.reg_write = 0; bus.reg_addr = 3'd6;
  endtask
  task automatic setup(input logic [15:0] src, input logic [7:0] len, input logic [7:0] sel, input logic [15:0] dest);
    wr(0, src[15:8]); wr(1, src[7:0]); wr(2, len); wr(3, sel); wr(4, dest[7:0]); wr(5, dest[15:8]);
  endtask
  task automatic expect_xfer(input logic [15:0] src, input logic [7:0] len, input logic [2:0] sel, input logic [15:0] dest);
    exp_t x;
    int n = (len == 0) ? 256 : int'(len);
    for (int i = 0; i < n; i++) begin
      x.src = src + 16'(i); x.dest = dest[11:0] + 12'(i); x.sel = sel;
      exp_rd.push_back(x.src);
      exp_wr.push_back(x);
    end
  endtask
  task automatic xfer(input logic [15:0] src, input logic [7:0] len, input logic [2:0] sel, input logic [15:0] dest);
    setup(src, len, {5'b0, sel}, dest);
    expect_xfer(src, len, sel, dest);
    wr(6, 8'h01);
  endtask
  task automatic wait_idle(input int budget);
    int n = 0;
    while (bus.reg_rdata[0] && n < budget) begin @(posedge clk); #1; n++; end
    chk("idle_timeout", bus.reg_rdata[0], 0);
  endtask
  task automatic wait_for(input bit we, input int budget);
    int n = 0;
    while (!(we ? bus.vram_write_enable : bus.mem_rd) && n < budget) begin @(posedge clk); #1; n++; end
    chk(we ? "we_timeout" : "rd_timeout", we ? bus.vram_write_enable : bus.mem_rd, 1);
  endtask
  task automatic sb_empty(input string tag);
    chk(tag, exp_rd.size() + exp_wr.size(), 0);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    logic [7:0] rb[8];
    int n, nw;
    rb = '{8'h12, 8'h00, 8'h04, 8'h03, 8'h10, 8'h00, 8'h00, 8'h00};
    bus.reg_write = 0; bus.reg_addr = 3'd6; bus.reg_wdata = 0; bus.bus_grant = 0;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    chk("rst_done", done_irq, 0);
    chk("rst_req", bus.bus_request, 0);
    for (int a = 0; a < 8; a++) begin bus.reg_addr = 3'(a); #1 chk("rst_reg", bus.reg_rdata, 0); end
    bus.reg_addr = 3'd6;
    setup(16'h1200, 8'd4, 8'd3, 16'h0010);
    for (int a = 0; a < 8; a++) begin bus.reg_addr = 3'(a); #1 chk("reg_rb", bus.reg_rdata, rb[a]); end
    bus.reg_addr = 3'd6;
    vb = 1; bus.bus_grant = 1;
    expect_xfer(16'h1200, 8'd4, 3'd3, 16'h0010);
    wr(6, 8'h01);
    wait_for(0, 20);
    n = 0;
    while (bus.reg_rdata[0] && n < 100) begin @(posedge clk); #1; n++; end
    chk("read_to_idle", n, 8);
    chk("irq_set", done_irq, 1);
    chk("ctrl_done", bus.reg_rdata, 8'h02);
    sb_empty("sb_basic");
    wr(6, 8'h02);
    chk("irq_clear", done_irq, 0);
    xfer(16'h0100, 8'd0, 3'd0, 16'h0FFE);
    wait_idle(700);
    sb_empty("sb_256_wrap");
    chk("irq_256", done_irq, 1);
    wr(6, 8'h02);
    xfer(16'h2000, 8'd5, 3'd2, 16'h0300);
    nw = 0;
    for (int i = 0; i < 50 && nw < 2; i++) begin @(posedge clk); #1; if (bus.vram_write_enable) nw++; end
    chk("vb_two", nw, 2);
    vb = 0;
    @(posedge clk); #1;
    repeat (6) begin
      chk("vb_req", bus.bus_request, 0);
      chk("vb_wait", bus.reg_rdata[2], 1);
      chk("vb_we", bus.vram_write_enable, 0);
      @(posedge clk); #1;
    end
    vb = 1;
    wait_idle(40);
    sb_empty("sb_vblank");
    chk("irq_vblank", done_irq, 1);
    wr(6, 8'h02);
    bus.bus_grant = 0;
    xfer(16'hFFFE, 8'd3, 3'd4, 16'h0ABC);
    repeat (3) begin @(posedge clk); #1; end
    repeat (4) begin
      chk("req_hold", bus.bus_request, 1);
      chk("req_nord", bus.mem_rd, 0);
      @(posedge clk); #1;
    end
    bus.bus_grant = 1;
    wait_idle(30);
    sb_empty("sb_src_wrap");
    wr(6, 8'h02);
    xfer(16'h3000, 8'd4, 3'd1, 16'h0040);
    wait_for(1, 20);
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    exp_rd.delete(); exp_wr.delete();
    chk("rst_mid_outs", {bus.bus_request, bus.mem_rd, bus.vram_write_enable, bus.mem_addr, bus.vram_address, bus.vram_data}, 0);
    chk("rst_mid_sel", {bus.SELECT_txbl, bus.SELECT_obm, bus.SELECT_ntbl, bus.SELECT_pmb, bus.SELECT_pmf}, 0);
    chk("rst_mid_irq", done_irq, 0);
    chk("rst_mid_ctrl", bus.reg_rdata, 0);
    bus.reg_addr = 3'd0; #1 chk("rst_mid_reg", bus.reg_rdata, 0);
    bus.reg_addr = 3'd6;
    repeat (3) begin @(posedge clk); #1; end
    chk("rst_no_irq", done_irq, 0);
    xfer(16'h3000, 8'd2, 3'd1, 16'h0040);
    wait_idle(30);
    sb_empty("sb_after_rst");
    chk("irq_after_rst", done_irq, 1);
    wr(6, 8'h02);
    bus.bus_grant = 0;
    xfer(16'h4000, 8'd3, 3'd0, 16'h0100);
    wr(0, 8'hAA);
    wr(3, 8'h06);
    wr(6, 8'h01);
    bus.bus_grant = 1;
    wait_idle(40);
    sb_empty("sb_busy_start");
    chk("irq_busy_start", done_irq, 1);
    bus.reg_addr = 3'd0; #1 chk("busy_wr_ign", bus.reg_rdata, 8'h40);
    bus.reg_addr = 3'd3; #1 chk("busy_sel_ign", bus.reg_rdata, 8'h00);
    bus.reg_addr = 3'd6;
    wr(6, 8'h02);
    wr(3, 8'h06);
    wr(6, 8'h01);
    repeat (5) begin
      chk("rsv_busy", bus.reg_rdata[0], 0);
      @(posedge clk); #1;
    end
    chk("rsv_irq", done_irq, 0);
    wr(3, 8'h02);
    wr(2, 8'h01);
    expect_xfer(16'h4000, 8'd1, 3'd2, 16'h0100);
    wr(6, 8'h01);
    wait_for(1, 20);
    wr(6, 8'h02);
    chk("irq_set_wins", done_irq, 1);
    wr(6, 8'h02);
    chk("irq_clear_end", done_irq, 0);
    sb_empty("sb_final");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
